// File: rtl/mult3b_pkg.sv
// Shared types and constants for the mult3b_arbiter cluster: FSM state
// encoding, operand/product widths and their typedefs.
package mult3b_pkg;

    localparam int OPW = 3;
    localparam int PW  = 6;

    typedef logic [OPW-1:0] operand_t;
    typedef logic [PW-1:0]  product_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mult3b_core.sv
// Combinational 3x3-bit unsigned multiplier. Both operands are widened to
// the product width before multiplying, so the 6-bit result is exact (max 49).
module mult3b_core
    import mult3b_pkg::*;
(
    input  operand_t a,
    input  operand_t b,
    output product_t m
);

    assign m = PW'(a) * PW'(b);

endmodule

// File: rtl/mult3b_arbiter.sv
// Shares one mult3b_core among NREQ requesters. Round-robin arbitration in
// IDLE, operands latched for one CALC cycle, result held in RESP until the
// consumer accepts it.
// Optional build macro: MULT3B_ARB_PRIO0_EN gives requester 0 absolute
// priority; the pointer then only advances on grants to other requesters.
module mult3b_arbiter
    import mult3b_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*OPW-1:0] req_a,
    input  logic [NREQ*OPW-1:0] req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [PW-1:0]       rsp_m,
    output logic                busy
);

    state_t         state_q, state_d;
    logic [IDW-1:0] p_q, p_d;
    operand_t       op_a_q, op_a_d;
    operand_t       op_b_q, op_b_d;
    logic [IDW-1:0] op_id_q, op_id_d;
    logic           rsp_valid_q, rsp_valid_d;
    product_t       rsp_m_q, rsp_m_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;

    logic           grant_found;
    logic [IDW-1:0] grant_id;
    product_t       core_m;
    int             idx;

    mult3b_core u_core (
        .a (op_a_q),
        .b (op_b_q),
        .m (core_m)
    );

    // Winner select: first valid requester at or after the pointer, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
`ifdef MULT3B_ARB_PRIO0_EN
        if (req_valid[0]) begin
            grant_found = 1'b1;
        end
`endif
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(p_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    // Next-state, operand capture, response update and grant strobe.
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_m_d     = rsp_m_q;
        rsp_id_d    = rsp_id_q;
        req_ready   = '0;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_id] = 1'b1;
                    op_a_d  = req_a[int'(grant_id)*OPW +: OPW];
                    op_b_d  = req_b[int'(grant_id)*OPW +: OPW];
                    op_id_d = grant_id;
                    state_d = CALC;
`ifdef MULT3B_ARB_PRIO0_EN
                    if (grant_id != '0) begin
                        p_d = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
                    end
`else
                    p_d = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
`endif
                end
            end
            CALC: begin
                rsp_m_d     = core_m;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Grants are suppressed while reset is asserted, even in IDLE.
        if (!rst_n) begin
            req_ready = '0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q     <= IDLE;
            p_q         <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_m_q     <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_m_q     <= rsp_m_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_m     = rsp_m_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult3b_arbiter.sv
// Self-checking bench for mult3b_arbiter (NREQ = 4): reset values, a
// hand-computed vector table, back-pressure, mid-operation reset, all 64
// operand pairs, and randomized transactions against a transaction-level model.
module tb_mult3b_arbiter;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [11:0] req_a;
    logic [11:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [5:0]  rsp_m;
    logic        busy;

    int n_run  = 0;
    int n_fail = 0;
    int mp     = 0;

    typedef struct {
        logic [3:0]  vld;
        logic [11:0] a;
        logic [11:0] b;
        int          id;
        int          m;
        int          stall;
    } vec_t;

    vec_t tbl[9];

    mult3b_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_m     (rsp_m),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int exp);
        n_run++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] pack(input int a3, input int a2, input int a1, input int a0);
        return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    // Reference arbitration: scan from the pointer, optionally with fixed priority for 0.
    function automatic int model_win(input int p, input logic [3:0] v);
`ifdef MULT3B_ARB_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int model_next_p(input int p, input int w);
`ifdef MULT3B_ARB_PRIO0_EN
        if (w == 0) return p;
`endif
        return (w + 1) % NREQ;
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        step();
        #1;
        check("reset req_ready", req_ready, 0);
        step();
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_m", rsp_m, 0);
        check("reset rsp_id", rsp_id, 0);
        check("reset busy", busy, 0);
        rst_n     = 1'b1;
        req_valid = '0;
        mp        = 0;
        step();
    endtask

    // One full transaction from an IDLE cycle; stall = cycles of rsp_ready low in RESP.
    task automatic txn(input string tag, input logic [3:0] vld, input logic [11:0] a,
                       input logic [11:0] b, input int exp_id, input int exp_m, input int stall);
        req_valid = vld;
        req_a     = a;
        req_b     = b;
        rsp_ready = 1'b0;
        #1;
        check({tag, " req_ready"}, req_ready, int'(4'b0001 << exp_id));
        step();
        req_valid = vld & ~(4'b0001 << exp_id);
        #1;
        check({tag, " calc busy"}, busy, 1);
        check({tag, " calc rsp_valid"}, rsp_valid, 0);
        check({tag, " calc req_ready"}, req_ready, 0);
        step();
        check({tag, " rsp_valid"}, rsp_valid, 1);
        check({tag, " rsp_m"}, rsp_m, exp_m);
        check({tag, " rsp_id"}, rsp_id, exp_id);
        for (int s = 0; s < stall; s++) begin
            step();
            check({tag, " hold rsp_valid"}, rsp_valid, 1);
            check({tag, " hold rsp_m"}, rsp_m, exp_m);
            check({tag, " hold rsp_id"}, rsp_id, exp_id);
            check({tag, " hold req_ready"}, req_ready, 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        req_valid = '0;
        check({tag, " done rsp_valid"}, rsp_valid, 0);
        check({tag, " done busy"}, busy, 0);
    endtask

    initial begin
        logic [3:0]  rv;
        logic [11:0] ra;
        logic [11:0] rb;
        int          w;
        int          em;

        tbl[0] = '{4'b1111, pack(2, 0, 6, 7), pack(2, 5, 3, 7), 0, 49, 0};
        tbl[1] = '{4'b1111, pack(2, 0, 6, 7), pack(2, 5, 3, 7), 1, 18, 0};
        tbl[2] = '{4'b1111, pack(2, 0, 6, 7), pack(2, 5, 3, 7), 2,  0, 0};
        tbl[3] = '{4'b1111, pack(2, 0, 6, 7), pack(2, 5, 3, 7), 3,  4, 1};
        tbl[4] = '{4'b1111, pack(2, 0, 6, 7), pack(2, 5, 3, 7), 0, 49, 0};
        tbl[5] = '{4'b0010, pack(0, 0, 3, 0), pack(0, 0, 5, 0), 1, 15, 2};
        tbl[6] = '{4'b1001, pack(5, 0, 0, 1), pack(6, 0, 0, 1), 3, 30, 0};
        tbl[7] = '{4'b0110, pack(0, 4, 3, 0), pack(0, 4, 5, 0), 1, 15, 0};
        tbl[8] = '{4'b0011, pack(0, 0, 1, 7), pack(0, 0, 1, 7), 0, 49, 0};

        do_reset();

`ifndef MULT3B_ARB_PRIO0_EN
        for (int i = 0; i < 9; i++) begin
            txn($sformatf("tbl%0d", i), tbl[i].vld, tbl[i].a, tbl[i].b,
                tbl[i].id, tbl[i].m, tbl[i].stall);
        end
`else
        // Requester 0 wins while valid; requester 1 gets the next grant once 0 drops.
        for (int i = 0; i < 3; i++) begin
            txn($sformatf("prio0_%0d", i), 4'b0011, pack(0, 0, 4, 2), pack(0, 0, 4, 3), 0, 6, 0);
        end
        txn("prio0_drop", 4'b0010, pack(0, 0, 4, 2), pack(0, 0, 4, 3), 1, 16, 0);
        txn("prio0_rr", 4'b1110, pack(1, 1, 1, 1), pack(3, 2, 1, 1), 2, 2, 0);
`endif

        // Back-pressure with requester 2 pending throughout RESP.
        req_valid = 4'b1000;
        req_a     = pack(1, 3, 0, 0);
        req_b     = pack(4, 3, 0, 0);
        rsp_ready = 1'b0;
        #1;
        check("bp grant3", req_ready, 4'b1000);
        step();
        req_valid = 4'b0100;
        #1;
        check("bp calc req_ready", req_ready, 0);
        step();
        check("bp rsp_m", rsp_m, 4);
        check("bp rsp_id", rsp_id, 3);
        for (int s = 0; s < 5; s++) begin
            step();
            check("bp hold rsp_valid", rsp_valid, 1);
            check("bp hold rsp_m", rsp_m, 4);
            check("bp hold rsp_id", rsp_id, 3);
            check("bp hold busy", busy, 1);
            check("bp hold req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp handshake req_ready", req_ready, 0);
        step();
        rsp_ready = 1'b0;
        #1;
        check("bp late grant2", req_ready, 4'b0100);
        check("bp idle rsp_valid", rsp_valid, 0);
        check("bp idle busy", busy, 0);
        step();
        req_valid = '0;
        step();
        check("bp second rsp_m", rsp_m, 9);
        check("bp second rsp_id", rsp_id, 2);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Reset while in CALC discards the transaction and rewinds the pointer.
        req_valid = 4'b0010;
        req_a     = pack(0, 0, 5, 0);
        req_b     = pack(0, 0, 5, 0);
        #1;
        check("mid grant1", req_ready, 4'b0010);
        step();
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        check("mid calc busy", busy, 1);
        step();
        check("mid rsp_valid", rsp_valid, 0);
        check("mid rsp_m", rsp_m, 0);
        check("mid rsp_id", rsp_id, 0);
        check("mid busy", busy, 0);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            step();
            check("mid no rsp", rsp_valid, 0);
        end
        txn("mid ptr0", 4'b1111, pack(1, 1, 1, 3), pack(1, 1, 1, 3), 0, 9, 0);

        // Every operand pair through requester 3.
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                txn($sformatf("exh %0dx%0d", a, b), 4'b1000, pack(a, 0, 0, 0),
                    pack(b, 0, 0, 0), 3, a * b, 0);
            end
        end

        // Randomized transactions against the reference model.
        do_reset();
        for (int i = 0; i < 150; i++) begin
            rv = 4'($urandom_range(1, 15));
            ra = 12'($urandom);
            rb = 12'($urandom);
            w  = model_win(mp, rv);
            em = int'(ra[w*3 +: 3]) * int'(rb[w*3 +: 3]);
            txn($sformatf("rnd%0d", i), rv, ra, rb, w, em, int'($urandom_range(0, 2)));
            mp = model_next_p(mp, w);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
